// File: rtl/psum_drain.sv
// psum_drain: reader side of the partial-sum accumulator. Counts terms per
// group, captures and requantises the finished sum, clears the accumulator
// and streams results through a small show-ahead FIFO.
module psum_drain #(
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [5:0]              cfg_shift,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] acc_in,
    output logic                    acc_rst_n,
    output logic                    stall,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COUNT, CAPTURE} state_t;

    state_t             state, nxt;
    logic [LEN_W-1:0]   len_q, cnt;
    logic [5:0]         shift_q;
    logic               latch, push, pop, space;

    logic signed [ACC_W:0] ext, rnd, rq;
    logic [OUT_W-1:0]      q_data;
    logic                  q_sat;

    logic [OUT_W:0]  mem [FIFO_DEPTH];
    logic [OUT_W:0]  head, push_word;
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_n;
    logic [CW-1:0]   fcnt, fcnt_n, remain;

    // Requantise: round half up in ACC_W+1 bits, then clamp to OUT_W signed.
    always_comb begin
        ext = {acc_in[ACC_W-1], acc_in};
        rnd = '0;
        if (shift_q != 6'd0)
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_q - 6'd1);
        rq = (ext + rnd) >>> shift_q;
        q_sat  = 1'b0;
        q_data = rq[OUT_W-1:0];
        if (rq > MAXV) begin
            q_sat  = 1'b1;
            q_data = MAXV[OUT_W-1:0];
        end else if (rq < MINV) begin
            q_sat  = 1'b1;
            q_data = MINV[OUT_W-1:0];
        end
    end

    assign push_word = {q_sat, q_data};
    assign out_valid = (fcnt != '0);
    assign pop       = out_valid & out_ready;
    assign space     = (fcnt < CW'(FIFO_DEPTH)) | pop;
    assign busy      = (state != IDLE) | out_valid;
    assign out_data  = head[OUT_W-1:0];
    assign out_sat   = head[OUT_W];

    // Next-state and handshake outputs; a capture only completes when the FIFO can take it.
    always_comb begin
        nxt       = state;
        acc_rst_n = 1'b1;
        stall     = 1'b1;
        push      = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                acc_rst_n = 1'b0;
                if (enable) begin
                    latch = 1'b1;
                    nxt   = COUNT;
                end
            end
            COUNT: begin
                stall = 1'b0;
                if (in_valid && cnt == len_q - LEN_W'(1))
                    nxt = CAPTURE;
            end
            CAPTURE: begin
                if (space) begin
                    push      = 1'b1;
                    acc_rst_n = 1'b0;
                    if (enable) begin
                        latch = 1'b1;
                        nxt   = COUNT;
                    end else begin
                        nxt = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // FSM state, latched config and term counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            len_q   <= LEN_W'(1);
            shift_q <= '0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            if (latch) begin
                len_q   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                shift_q <= cfg_shift;
                cnt     <= '0;
            end else if (state == COUNT && in_valid) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

    // FIFO bookkeeping; remain is what is left of the old contents after a pop.
    always_comb begin
        rd_n   = rd_ptr + PW'(pop);
        fcnt_n = fcnt + CW'(push) - CW'(pop);
        remain = fcnt - CW'(pop);
    end

    // FIFO storage has no reset; only the head register is visible outside.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

    // Pointers, occupancy and registered head; head holds while the FIFO is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_n;
            fcnt   <= fcnt_n;
            if (fcnt_n != '0)
                head <= (remain == '0) ? push_word : mem[rd_n];
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed table plus hand sequences for psum_drain, with a
// behavioural accumulator feeding acc_in.
module tb_psum_drain;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic [15:0]        cfg_len = 16'd1;
    logic [5:0]         cfg_shift = 6'd0;
    logic               in_valid = 1'b0;
    logic signed [39:0] term = '0;
    logic signed [39:0] acc = '0;
    logic               acc_rst_n, stall, busy, out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic               out_sat;

    int checks = 0;
    int errors = 0;

    psum_drain dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .acc_in(acc),
        .acc_rst_n(acc_rst_n), .stall(stall), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Accumulator model with its active-low synchronous clear.
    always @(posedge clk) begin
        if (!acc_rst_n) acc <= '0;
        else if (in_valid) acc <= acc + term;
    end

    typedef struct {
        logic [15:0]        len;
        logic [5:0]         shift;
        logic signed [39:0] term;
        longint             exp_d;
        longint             exp_s;
    } vec_t;

    vec_t vt[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_stall_low(input string nm);
        int n = 0;
        while (stall && n < 20) begin
            tick;
            n++;
        end
        chk(nm, longint'(stall), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{16'd1, 6'd0,  40'sd10,               10,     0};
        vt[1]  = '{16'd1, 6'd2,  40'sd5,                1,      0};
        vt[2]  = '{16'd1, 6'd2, -40'sd5,                -1,     0};
        vt[3]  = '{16'd1, 6'd0,  40'sh00_0001_0000,     32767,  1};
        vt[4]  = '{16'd1, 6'd0, -40'sd70000,            -32768, 1};
        vt[5]  = '{16'd1, 6'd4,  40'sd24,               2,      0};
        vt[6]  = '{16'd1, 6'd4, -40'sd24,               -1,     0};
        vt[7]  = '{16'd1, 6'd1, -40'sd3,                -1,     0};
        vt[8]  = '{16'd1, 6'd8,  40'sh7F_FFFF_FFFF,     32767,  1};
        vt[9]  = '{16'd1, 6'd0,  40'sd32767,            32767,  0};
        vt[10] = '{16'd1, 6'd0, -40'sd32768,            -32768, 0};
        vt[11] = '{16'd1, 6'd1,  40'sd65535,            32767,  1};
        vt[12] = '{16'd1, 6'd39, 40'sh80_0000_0000,     -1,     0};
        vt[13] = '{16'd0, 6'd0,  40'sd7,                7,      0};

        // Reset state
        #3;
        chk("rst_acc_rst_n", longint'(acc_rst_n), 0);
        chk("rst_stall",     longint'(stall), 1);
        chk("rst_busy",      longint'(busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data",  longint'(out_data), 0);
        chk("rst_out_sat",   longint'(out_sat), 0);
        tick; tick;
        reset = 1'b1;
        tick;

        // Table: single-term groups exercising requantisation
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cfg_len   = vt[i].len;
            cfg_shift = vt[i].shift;
            enable    = 1'b1;
            wait_stall_low("tbl_start");
            in_valid = 1'b1;
            term     = vt[i].term;
            tick;
            in_valid = 1'b0;
            enable   = 1'b0;
            chk("tbl_clear", longint'(acc_rst_n), 0);
            tick;
            chk("tbl_valid", longint'(out_valid), 1);
            chk("tbl_data",  longint'(out_data), vt[i].exp_d);
            chk("tbl_sat",   longint'(out_sat), vt[i].exp_s);
            tick;
        end

        // T1: len=4, terms 1..4, latency and single-cycle clear
        cfg_len = 16'd4; cfg_shift = 6'd0; enable = 1'b1;
        wait_stall_low("t1_start");
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            term     = 40'(i);
            tick;
        end
        in_valid = 1'b0;
        chk("t1_cap_stall", longint'(stall), 1);
        chk("t1_cap_clear", longint'(acc_rst_n), 0);
        chk("t1_cap_valid", longint'(out_valid), 0);
        tick;
        chk("t1_valid",     longint'(out_valid), 1);
        chk("t1_data",      longint'(out_data), 10);
        chk("t1_sat",       longint'(out_sat), 0);
        chk("t1_clear_off", longint'(acc_rst_n), 1);
        chk("t1_count",     longint'(stall), 0);

        // T5: drop enable mid-group; group completes then FSM idles
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            term     = 40'sd5;
            tick;
        end
        in_valid = 1'b0;
        chk("t5_cap_clear", longint'(acc_rst_n), 0);
        tick;
        chk("t5_valid",     longint'(out_valid), 1);
        chk("t5_data",      longint'(out_data), 20);
        chk("t5_idle_clr",  longint'(acc_rst_n), 0);
        chk("t5_idle_stall", longint'(stall), 1);
        chk("t5_busy",      longint'(busy), 1);
        tick;
        chk("t5_drained",   longint'(busy), 0);

        // T4: fill FIFO with out_ready=0, fifth group holds in CAPTURE
        out_ready = 1'b0; cfg_len = 16'd1; enable = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_stall_low("t4_start");
            in_valid = 1'b1;
            term     = 40'(100 + g);
            tick;
            in_valid = 1'b0;
        end
        tick; tick;
        chk("t4_hold_stall", longint'(stall), 1);
        chk("t4_hold_clr",   longint'(acc_rst_n), 1);
        chk("t4_head",       longint'(out_data), 100);
        out_ready = 1'b1;
        enable    = 1'b0;
        #1;
        chk("t4_pushpop_clr", longint'(acc_rst_n), 0);
        tick;
        out_ready = 1'b0;
        chk("t4_after_pop",  longint'(out_data), 101);
        tick;
        chk("t4_no_pop",     longint'(out_data), 101);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t4_order", longint'(out_data), 100 + k);
            tick;
        end
        chk("t4_empty", longint'(out_valid), 0);
        chk("t4_hold",  longint'(out_data), 104);
        chk("t4_busy",  longint'(busy), 0);

        // T6: async reset mid-group with two FIFO entries
        out_ready = 1'b0; cfg_len = 16'd1; enable = 1'b1;
        wait_stall_low("t6_g0");
        in_valid = 1'b1; term = 40'sd1; tick; in_valid = 1'b0;
        wait_stall_low("t6_g1");
        in_valid = 1'b1; term = 40'sd2; cfg_len = 16'd3; tick; in_valid = 1'b0;
        wait_stall_low("t6_g2");
        in_valid = 1'b1; term = 40'sd7; tick; in_valid = 1'b0;
        chk("t6_pre_busy",  longint'(busy), 1);
        chk("t6_pre_valid", longint'(out_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", longint'(out_valid), 0);
        chk("t6_rst_clr",   longint'(acc_rst_n), 0);
        chk("t6_rst_busy",  longint'(busy), 0);
        chk("t6_rst_stall", longint'(stall), 1);
        tick; tick;
        reset = 1'b1;
        cfg_len = 16'd1; out_ready = 1'b1; enable = 1'b1;
        wait_stall_low("t6_restart");
        in_valid = 1'b1; term = 40'sd9; tick;
        in_valid = 1'b0; enable = 1'b0;
        tick;
        chk("t6_fresh_valid", longint'(out_valid), 1);
        chk("t6_fresh_data",  longint'(out_data), 9);
        tick;
        chk("t6_fresh_empty", longint'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
